// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: base address, access width
// codes, FSM encoding and the byte-lane helpers used for stores and loads.
package dmem_pkg;

    localparam logic [31:0] DMEM_BASE = 32'h10010000;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            W_BYTE:  be = 4'b0001 << off;
            W_HALF:  be = 4'b0011 << off;
            W_WORD:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] d);
        logic [31:0] res;
        case (width)
            W_BYTE:  res = {4{d[7:0]}};
            W_HALF:  res = {2{d[15:0]}};
            default: res = d;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] width,
                                             input logic [1:0] off, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            W_BYTE:  res = ext ? {24'h0, b} : {{24{b[7]}}, b};
            W_HALF:  res = ext ? {16'h0, h} : {{16{h[15]}}, h};
            W_WORD:  res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// MA-stage data-port bundle between the core (master) and the memory responder (slave).
interface dmem_resp_if;
    logic        r_ena;
    logic        w_ena;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        ext;
    logic [31:0] data_in;
    logic        valid;
    logic [31:0] data_out;
    logic        fault;

    modport master (
        output r_ena, w_ena, addr, width, ext, data_in,
        input  valid, data_out, fault
    );

    modport slave (
        input  r_ena, w_ena, addr, width, ext, data_in,
        output valid, data_out, fault
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised backing store with per-byte write enables. The read port is
// combinational, so a read on the write edge observes the pre-write word.
module dmem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = r_mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: wait-state FSM, range/alignment checking, byte-lane
// store masking and load extension in front of dmem_array.
//
//   state  | meaning
//   IDLE   | ready; with zero latency accesses complete here back-to-back
//   WAIT   | access latched, counting wait states down to zero
//   DONE   | access just completed; ready and may accept the next one
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 0,
    parameter logic [31:0] BASE    = DMEM_BASE
) (
    input  logic       clk,
    input  logic       rst,
    dmem_resp_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      r_state;
    logic        r_valid;
    logic [31:0] r_dout;
    logic        r_fault;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_wr;
    logic        r_ext;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [1:0]  r_width;

    logic        w_accept;
    logic        w_go;
    logic        w_rd;
    logic        w_wr;
    logic        w_ext;
    logic [31:0] w_addr;
    logic [31:0] w_din;
    logic [1:0]  w_width;
    logic [31:0] w_off;
    logic        w_oor;
    logic        w_mis;
    logic        w_bad;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [IW-1:0] w_idx;

    // The access is performed either straight from the bus (no wait states)
    // or from the latched request on the last WAIT cycle.
    always_comb begin
        w_accept = (r_state != S_WAIT) && (bus.r_ena || bus.w_ena);
        if (LATENCY == 0) begin
            w_go    = w_accept;
            w_rd    = bus.r_ena;
            w_wr    = bus.w_ena;
            w_ext   = bus.ext;
            w_addr  = bus.addr;
            w_din   = bus.data_in;
            w_width = bus.width;
        end else begin
            w_go    = (r_state == S_WAIT) && (r_cnt == 4'd0);
            w_rd    = r_rd;
            w_wr    = r_wr;
            w_ext   = r_ext;
            w_addr  = r_addr;
            w_din   = r_din;
            w_width = r_width;
        end
    end

    assign w_off   = w_addr - BASE;
    assign w_oor   = (w_addr < BASE) || ({2'b00, w_off[31:2]} >= 32'(DEPTH));
    assign w_mis   = ((w_width == W_HALF) && w_off[0])
                  || ((w_width == W_WORD) && (w_off[1:0] != 2'b00))
                  || (w_width == 2'b11);
    assign w_bad   = w_oor || w_mis;
    assign w_idx   = w_off[IW+1:2];
    assign w_we    = w_go && w_wr && !w_bad && !rst;
    assign w_be    = lane_be(w_width, w_off[1:0]);
    assign w_wdata = lane_wdata(w_width, w_din);

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (w_we),
        .be    (w_be),
        .idx   (w_idx),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b1;
            r_dout  <= 32'h0;
            r_fault <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_fault <= w_go && w_bad;
            if (w_go) begin
                if (w_bad)     r_dout <= 32'h0;
                else if (w_rd) r_dout <= load_fmt(w_rdata, w_width, w_off[1:0], w_ext);
            end
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_rd    <= bus.r_ena;
                        r_wr    <= bus.w_ena;
                        r_ext   <= bus.ext;
                        r_addr  <= bus.addr;
                        r_din   <= bus.data_in;
                        r_width <= bus.width;
                        if (LATENCY != 0) begin
                            r_state <= S_WAIT;
                            r_valid <= 1'b0;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.valid    = r_valid;
    assign bus.data_out = r_dout;
    assign bus.fault    = r_fault;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a zero-latency and a three-wait-state instance share one
// stimulus stream; a byte-addressed model predicts valid/data_out/fault each cycle.
module tb_dmem_resp;
    import dmem_pkg::*;

    localparam int          DEPTH = 256;
    localparam int          LAT1  = 3;
    localparam logic [31:0] B     = DMEM_BASE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        t_r, t_w, t_ext;
    logic [31:0] t_addr, t_din;
    logic [1:0]  t_width;

    dmem_resp_if bus0();
    dmem_resp_if bus1();

    assign bus0.r_ena = t_r;    assign bus1.r_ena = t_r;
    assign bus0.w_ena = t_w;    assign bus1.w_ena = t_w;
    assign bus0.addr = t_addr;  assign bus1.addr = t_addr;
    assign bus0.width = t_width; assign bus1.width = t_width;
    assign bus0.ext = t_ext;    assign bus1.ext = t_ext;
    assign bus0.data_in = t_din; assign bus1.data_in = t_din;

    dmem_resp #(.DEPTH(DEPTH), .LATENCY(0), .BASE(B)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT1), .BASE(B)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model: byte memory, cycles-until-done, pending request.
    logic [7:0]  m_mem [2][DEPTH*4];
    int          m_busy [2];
    logic [31:0] m_dout [2];
    bit          m_fault [2];
    bit          p_r [2], p_w [2], p_e [2];
    logic [31:0] p_a [2], p_d [2];
    logic [1:0]  p_wd [2];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic perform(int k, bit r, bit w, logic [31:0] a, logic [1:0] wd, bit e, logic [31:0] d);
        int n;
        int ba;
        logic [31:0] v;
        n = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : 4;
        if (wd == 2'd3 || a < B || (a - B) >= 32'(DEPTH*4) || (a % 32'(n)) != 0) begin
            m_dout[k]  = 32'h0;
            m_fault[k] = 1'b1;
            return;
        end
        ba = int'(a - B);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[k][ba+i];
        if (n < 4 && !e && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        if (w) begin
            for (int i = 0; i < n; i++) m_mem[k][ba+i] = d[8*i +: 8];
        end
        if (r) m_dout[k] = v;
    endtask

    task automatic step(int k, int lat);
        m_fault[k] = 1'b0;
        if (rst) begin
            m_busy[k] = 0;
            m_dout[k] = 32'h0;
            return;
        end
        if (m_busy[k] > 0) begin
            m_busy[k]--;
            if (m_busy[k] == 0) perform(k, p_r[k], p_w[k], p_a[k], p_wd[k], p_e[k], p_d[k]);
        end else if (t_r || t_w) begin
            if (lat == 0) begin
                perform(k, t_r, t_w, t_addr, t_width, t_ext, t_din);
            end else begin
                p_r[k] = t_r; p_w[k] = t_w; p_a[k] = t_addr;
                p_wd[k] = t_width; p_e[k] = t_ext; p_d[k] = t_din;
                m_busy[k] = lat;
            end
        end
    endtask

    always @(posedge clk) begin
        step(0, 0);
        step(1, LAT1);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_valid0", 32'(bus0.valid), 32'(m_busy[0] == 0));
            chk("cyc_fault0", 32'(bus0.fault), 32'(m_fault[0]));
            chk("cyc_dout0",  bus0.data_out,   m_dout[0]);
            chk("cyc_valid1", 32'(bus1.valid), 32'(m_busy[1] == 0));
            chk("cyc_fault1", 32'(bus1.fault), 32'(m_fault[1]));
            chk("cyc_dout1",  bus1.data_out,   m_dout[1]);
        end
    end

    task automatic drive(bit r, bit w, logic [31:0] a, logic [1:0] wd, bit e, logic [31:0] d);
        t_r = r; t_w = w; t_addr = a; t_width = wd; t_ext = e; t_din = d;
    endtask

    task automatic idle();
        t_r = 1'b0; t_w = 1'b0;
    endtask

    // safe=1 keeps any store inside a scratch region the directed checks never read.
    task automatic rnd_drive(bit safe);
        int sel;
        int wsel;
        t_r = 1'($urandom_range(0, 1));
        t_w = 1'($urandom_range(0, 1));
        t_ext = 1'($urandom_range(0, 1));
        t_din = $urandom;
        wsel = $urandom_range(0, 9);
        t_width = (wsel == 9) ? 2'b11 : 2'(wsel % 3);
        if (safe) begin
            t_addr = B + 32'h200 + 32'($urandom_range(0, 255));
        end else begin
            sel = $urandom_range(0, 11);
            if (sel < 8)       t_addr = B + 32'($urandom_range(0, 127));
            else if (sel == 8) t_addr = B - 32'($urandom_range(1, 8));
            else if (sel == 9) t_addr = B + 32'(DEPTH*4 - 4) + 32'($urandom_range(0, 7));
            else if (sel == 10) t_addr = $urandom;
            else               t_addr = B + 32'($urandom_range(0, DEPTH*4 - 1));
        end
    endtask

    task automatic op(string nm, bit r, bit w, logic [31:0] a, logic [1:0] wd, bit e, logic [31:0] d,
                      logic [31:0] x0, bit f0, logic [31:0] x1, bit f1, bit tog);
        @(negedge clk); #1;
        drive(r, w, a, wd, e, d);
        @(negedge clk);
        chk({nm, "_valid0"}, 32'(bus0.valid), 32'd1);
        chk({nm, "_dout0"},  bus0.data_out, x0);
        chk({nm, "_fault0"}, 32'(bus0.fault), 32'(f0));
        chk({nm, "_model0"}, m_dout[0], x0);
        chk({nm, "_busy1"},  32'(bus1.valid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            if (tog) rnd_drive(1'b1); else idle();
            @(negedge clk);
            chk({nm, "_busy1"}, 32'(bus1.valid), 32'd0);
        end
        #1;
        if (tog) rnd_drive(1'b1); else idle();
        @(negedge clk);
        chk({nm, "_valid1"}, 32'(bus1.valid), 32'd1);
        chk({nm, "_dout1"},  bus1.data_out, x1);
        chk({nm, "_fault1"}, 32'(bus1.fault), 32'(f1));
        chk({nm, "_model1"}, m_dout[1], x1);
        #1 idle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_dout[k] = 32'h0; m_fault[k] = 1'b0;
            for (int i = 0; i < DEPTH*4; i++) m_mem[k][i] = 8'h00;
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, B, W_WORD, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid0", 32'(bus0.valid), 32'd1);
        chk("rst_dout0",  bus0.data_out, 32'h0);
        chk("rst_fault0", 32'(bus0.fault), 32'd0);
        chk("rst_valid1", 32'(bus1.valid), 32'd1);
        chk("rst_dout1",  bus1.data_out, 32'h0);
        cmp_on = 1'b1;
        #1 rst = 1'b0;

        // Bring the backing arrays to a known all-zero state.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); #1 drive(1'b0, 1'b1, B + 32'(4*i), W_WORD, 1'b0, 32'h0);
            @(negedge clk); #1 idle();
            repeat (3) @(negedge clk);
        end

        op("sw4",   0, 1, B+4,  W_WORD, 0, 32'hDEADBEEF, 32'h0, 0, 32'h0, 0, 0);
        op("lw4",   1, 0, B+4,  W_WORD, 0, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        op("sb6",   0, 1, B+6,  W_BYTE, 0, 32'h00000080, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        op("lb6",   1, 0, B+6,  W_BYTE, 0, 32'h0, 32'hFFFFFF80, 0, 32'hFFFFFF80, 0, 0);
        op("lbu6",  1, 0, B+6,  W_BYTE, 1, 32'h0, 32'h00000080, 0, 32'h00000080, 0, 0);
        op("lw4b",  1, 0, B+4,  W_WORD, 0, 32'h0, 32'hDE80BEEF, 0, 32'hDE80BEEF, 0, 1);
        op("lh6",   1, 0, B+6,  W_HALF, 0, 32'h0, 32'hFFFFDE80, 0, 32'hFFFFDE80, 0, 0);
        op("lhu6",  1, 0, B+6,  W_HALF, 1, 32'h0, 32'h0000DE80, 0, 32'h0000DE80, 0, 0);
        op("lh1",   1, 0, B+1,  W_HALF, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0);
        op("swoor", 0, 1, 32'h1000FFFC, W_WORD, 0, 32'h55, 32'h0, 1, 32'h0, 1, 0);
        op("w11",   0, 1, B+4,  2'b11,  0, 32'h0, 32'h0, 1, 32'h0, 1, 0);
        op("swmis", 0, 1, B+6,  W_WORD, 0, 32'h11111111, 32'h0, 1, 32'h0, 1, 0);
        op("lw4c",  1, 0, B+4,  W_WORD, 0, 32'h0, 32'hDE80BEEF, 0, 32'hDE80BEEF, 0, 0);
        op("rw8",   1, 1, B+8,  W_WORD, 0, 32'h12345678, 32'h0, 0, 32'h0, 0, 0);
        op("lw8",   1, 0, B+8,  W_WORD, 0, 32'h0, 32'h12345678, 0, 32'h12345678, 0, 0);
        op("sh10",  0, 1, B+10, W_HALF, 0, 32'hFFFFABCD, 32'h12345678, 0, 32'h12345678, 0, 0);
        op("lh10",  1, 0, B+10, W_HALF, 0, 32'h0, 32'hFFFFABCD, 0, 32'hFFFFABCD, 0, 0);
        op("lw8b",  1, 0, B+8,  W_WORD, 0, 32'h0, 32'hABCD5678, 0, 32'hABCD5678, 0, 0);
        op("lbu9",  1, 0, B+9,  W_BYTE, 1, 32'h0, 32'h00000056, 0, 32'h00000056, 0, 0);
        op("rwb4",  1, 1, B+4,  W_BYTE, 0, 32'h0000007F, 32'hFFFFFFEF, 0, 32'hFFFFFFEF, 0, 0);
        op("lw4d",  1, 0, B+4,  W_WORD, 0, 32'h0, 32'hDE80BE7F, 0, 32'hDE80BE7F, 0, 0);
        op("swtop", 0, 1, B+32'(DEPTH*4-4), W_WORD, 0, 32'hA5A5A5A5, 32'hDE80BE7F, 0, 32'hDE80BE7F, 0, 0);
        op("lwtop", 1, 0, B+32'(DEPTH*4-4), W_WORD, 0, 32'h0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0);
        op("lwoor", 1, 0, B+32'(DEPTH*4),   W_WORD, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0);

        // Reset while the wait-state instance holds a pending write.
        @(negedge clk); #1 drive(1'b0, 1'b1, B+16, W_WORD, 1'b0, 32'hAAAAAAAA);
        @(negedge clk); #1 begin idle(); rst = 1'b1; end
        @(negedge clk);
        chk("rstw_valid1", 32'(bus1.valid), 32'd1);
        chk("rstw_dout1",  bus1.data_out, 32'h0);
        chk("rstw_fault1", 32'(bus1.fault), 32'd0);
        #1 rst = 1'b0;
        op("lw16", 1, 0, B+16, W_WORD, 0, 32'h0, 32'hAAAAAAAA, 0, 32'h0, 0, 0);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 99) < 15) idle(); else rnd_drive(1'b0);
        end
        @(negedge clk); #1 idle();
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the core's MA-stage data port: the memory side of the `r_ena`/`w_ena`/`addr`/`width`/`ext`/`data_in` → `valid`/`data_out` interface.
- Replaces the always-valid stub with a real responder:
  - programmable wait states;
  - byte/half/word stores with byte-lane masking;
  - load sign/zero extension;
  - alignment and range checking.
- Backed by a word-organised on-chip array at `DMEM_BASE`.

Parameters:
- `DEPTH`, 1024, number of 32-bit words in the backing array (power of 2).
- `LATENCY`, 0, extra wait-state cycles per access (0..15).
- `BASE`, 32'h10010000, byte address of word 0.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `r_ena`  in  1  read request (sampled only while `valid`=1).
- `w_ena`  in  1  write request (sampled only while `valid`=1).
- `addr`  in  32  byte address.
- `width`  in  2  00 byte, 01 half, 10 word, 11 illegal (`funct3[1:0]`).
- `ext`  in  1  `funct3[2]`: 0 = sign-extend load, 1 = zero-extend load; ignored for writes.
- `data_in`  in  32  store data; the low byte/half/word is used.
- `valid`  out  1  1 = idle/ready and last response complete; 0 = busy.
- `data_out`  out  32  load result, registered; held until the next completed read.
- `fault`  out  1  one-cycle pulse on completion of a misaligned, out-of-range or illegal-width access.

Behaviour:
- Reset state (`rst`=1 at posedge):
  - state IDLE, `valid`=1, `data_out`=0, `fault`=0, wait counter 0.
  - Array contents are not cleared.
  - Reset mid-access aborts it; a pending write is discarded.
- Request acceptance:
  - A request is accepted at a posedge with `valid`=1 and (`r_ena`|`w_ena`).
  - `addr`, `width`, `ext`, `data_in` and the read/write flags are latched at acceptance.
  - While `valid`=0, all inputs are ignored; the initiator must stall.
- FSM states: IDLE, WAIT, DONE.
  - IDLE → (accept, `LATENCY`=0) → the access is performed at the accept edge; result appears on the next cycle; `valid` stays 1; state stays IDLE. This gives back-to-back single-cycle throughput.
  - IDLE → (accept, `LATENCY`>0) → WAIT; `valid`=0; counter loaded with `LATENCY`-1.
  - WAIT: counter decrements each cycle. At 0 → DONE; the access is performed on this transition edge.
  - DONE: `valid`=1, `data_out`/`fault` updated this cycle → IDLE. A new request may be accepted in DONE (same rules as IDLE).
  - Read latency is 1 cycle for `LATENCY`=0 and `LATENCY`+1 cycles otherwise, counted from the accept edge to `data_out` valid.
- Address:
  - Word index = (`addr`-`BASE`)>>2; byte offset = `addr[1:0]`.
  - Out of range when `addr` < `BASE` or index ≥ `DEPTH`.
- Faults:
  - Causes: out of range, half with `addr[0]`=1, word with `addr[1:0]`≠0, or `width`=11.
  - On a fault: no array write, `data_out`=0, `fault`=1 for exactly the completion cycle.
- Write:
  - Byte enables: byte → `1<<off`; half → `2'b11<<off`; word → 4'hF.
  - Lane data is replicated: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`.
  - Bytes not enabled are unchanged.
- Read:
  - Select the byte/half at the offset.
  - Extend to 32 bits per `ext` (0 = sign, 1 = zero); word reads are unmodified.
- Simultaneous `r_ena` and `w_ena`:
  - The write is performed.
  - `data_out` returns the pre-write contents (read-before-write), formatted per `width`/`ext`.
- Write-only access: `data_out` holds its previous value.
- `fault` is 0 on every non-completion cycle.

Decomposition:
- Package `dmem_pkg`:
  - `DMEM_BASE` = 32'h10010000;
  - width codes `W_BYTE`=2'b00, `W_HALF`=2'b01, `W_WORD`=2'b10;
  - FSM state encoding (IDLE, WAIT, DONE).
- Sub-module `dmem_array`:
  - `DEPTH`×32 synchronous array;
  - ports `clk`, `we`, `be`[3:0], `idx`, `wdata`, `rdata`;
  - read-before-write on the same edge.
- Lane formatting, alignment check and FSM live in `dmem_resp`.

Test Plan:
- `LATENCY`=0: word write 0xDEADBEEF @0x10010004, then word read @0x10010004 → `data_out`=0xDEADBEEF one cycle after the read is accepted; `valid` never drops.
- Byte store 0x80 @0x10010006 over 0xDEADBEEF; `lb` (`ext`=0) @0x10010006 → 0xFFFFFF80; `lbu` (`ext`=1) → 0x00000080; word read → 0xDE80BEEF.
- `LATENCY`=3: read accepted at edge N → `valid`=0 for cycles N+1..N+3; `valid`=1 with data at N+4; inputs toggled during busy are ignored.
- Faults: half read @0x10010001 → `fault`=1 for one cycle, `data_out`=0. Word write @0x1000FFFC → `fault`=1 and no memory change. `width`=11 → `fault`=1.
- `r_ena`=`w_ena`=1 with word 0x12345678 @0x10010008 (old 0x0) → `data_out`=0x0; subsequent read → 0x12345678.
- `rst` asserted during WAIT of a write → next cycle `valid`=1, `data_out`=0, `fault`=0; the target word is unchanged.
